alu_acc_seq: RTL and testbench

Parametrised successor of the 8-bit ALU + accumulator + carry-register datapath. Integrates the accumulator (A), carry flag (CY), zero flag (ZF) and a high-product register into one clocked unit. Adds a start/busy/done handshake, rotate-through-carry ops and a multi-cycle shift-add multiplier. Sits between the controller/decoder and the register file; R is the second operand taken from the register file or an immediate.

---
 rtl/alu_acc_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_acc_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_acc_seq
//  Purpose  : Accumulator datapath with carry and zero flags and a
//             start/busy/done handshake. Single-cycle ALU ops (LD, ADD, SUB,
//             AND, OR, XOR, NOT, CLC, RCL, RCR) plus an optional multi-cycle
//             unsigned shift-add multiplier (MUL).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in   rising-edge clock
//    nReset  in   asynchronous active-low reset
//    start   in   request, sampled only while busy=0
//    op      in   [3:0] operation code, sampled with start
//    r       in   [WIDTH-1:0] second operand, sampled with start
//    acc     out  [WIDTH-1:0] accumulator A
//    acc_hi  out  [WIDTH-1:0] high half of the last MUL product
//    cy      out  carry / borrow flag
//    zf      out  zero flag of the last A-writing op
//    busy    out  multiply in progress
//    done    out  one-cycle completion pulse
//    err     out  one-cycle illegal-op pulse
//  Build option
//    ALU_MUL_EN  defined: MUL (op 10), acc_hi, MUL state and counter built.
//                undefined: op 10 is illegal, acc_hi=0, busy=0.
// ============================================================================
module alu_acc_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_hi,
  output logic             cy,
  output logic             zf,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] c_OP_LD  = 4'd0;
  localparam logic [3:0] c_OP_ADD = 4'd1;
  localparam logic [3:0] c_OP_SUB = 4'd2;
  localparam logic [3:0] c_OP_AND = 4'd3;
  localparam logic [3:0] c_OP_OR  = 4'd4;
  localparam logic [3:0] c_OP_XOR = 4'd5;
  localparam logic [3:0] c_OP_NOT = 4'd6;
  localparam logic [3:0] c_OP_CLC = 4'd7;
  localparam logic [3:0] c_OP_RCL = 4'd8;
  localparam logic [3:0] c_OP_RCR = 4'd9;
  localparam logic [3:0] c_OP_MUL = 4'd10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_cy;
  logic             r_zf;
  logic             r_done;
  logic             r_err;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_cy_n;
  logic             w_wr_a;
  logic             w_illegal;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_mcand;
  // Product shadow: r_p_hi accumulates partial sums, r_p_lo starts as the
  // multiplier and is shifted out LSB-first while product bits shift in.
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             w_is_mul;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_p_hi_n;
  logic [WIDTH-1:0] w_p_lo_n;

  assign w_sum    = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_p_hi_n = w_sum[WIDTH:1];
  assign w_p_lo_n = {w_sum[0], r_p_lo[WIDTH-1:1]};
`endif

  // Borrow falls out as the extra MSB of the widened subtraction.
  assign w_add = {1'b0, r_acc} + {1'b0, r} + {{WIDTH{1'b0}}, r_cy};
  assign w_sub = {1'b0, r_acc} - {1'b0, r} - {{WIDTH{1'b0}}, r_cy};

  always_comb begin
    w_res     = r_acc;
    w_cy_n    = r_cy;
    w_wr_a    = 1'b1;
    w_illegal = 1'b0;
`ifdef ALU_MUL_EN
    w_is_mul  = 1'b0;
`endif
    case (op)
      c_OP_LD:  w_res = r;
      c_OP_ADD: begin
        w_res  = w_add[WIDTH-1:0];
        w_cy_n = w_add[WIDTH];
      end
      c_OP_SUB: begin
        w_res  = w_sub[WIDTH-1:0];
        w_cy_n = w_sub[WIDTH];
      end
      c_OP_AND: w_res = r_acc & r;
      c_OP_OR:  w_res = r_acc | r;
      c_OP_XOR: w_res = r_acc ^ r;
      c_OP_NOT: w_res = ~r_acc;
      c_OP_CLC: begin
        w_cy_n = 1'b0;
        w_wr_a = 1'b0;
      end
      c_OP_RCL: begin
        w_res  = {r_acc[WIDTH-2:0], r_cy};
        w_cy_n = r_acc[WIDTH-1];
      end
      c_OP_RCR: begin
        w_res  = {r_cy, r_acc[WIDTH-1:1]};
        w_cy_n = r_acc[0];
      end
      c_OP_MUL: begin
`ifdef ALU_MUL_EN
        w_is_mul  = 1'b1;
        w_wr_a    = 1'b0;
`else
        w_illegal = 1'b1;
`endif
      end
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cy     <= 1'b0;
      r_zf     <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef ALU_MUL_EN
      r_acc_hi <= '0;
      r_mcand  <= '0;
      r_p_hi   <= '0;
      r_p_lo   <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_illegal) begin
              r_err <= 1'b1;
`ifdef ALU_MUL_EN
            end else if (w_is_mul) begin
              r_mcand <= r_acc;
              r_p_hi  <= '0;
              r_p_lo  <= r;
              r_cnt   <= '0;
              r_state <= S_MUL;
`endif
            end else begin
              r_acc  <= w_res;
              r_cy   <= w_cy_n;
              if (w_wr_a) begin
                r_zf <= (w_res == '0);
              end
              r_done <= 1'b1;
            end
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          r_p_hi <= w_p_hi_n;
          r_p_lo <= w_p_lo_n;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Last iteration: publish the freshly computed product directly.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_acc    <= w_p_lo_n;
            r_acc_hi <= w_p_hi_n;
            r_cy     <= |w_p_hi_n;
            r_zf     <= (w_p_lo_n == '0);
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign acc  = r_acc;
  assign cy   = r_cy;
  assign zf   = r_zf;
  assign done = r_done;
  assign err  = r_err;
`ifdef ALU_MUL_EN
  assign acc_hi = r_acc_hi;
  assign busy   = (r_state == S_MUL);
`else
  assign acc_hi = '0;
  assign busy   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_acc_seq
//  Purpose  : Scoreboard bench for alu_acc_seq (WIDTH=8). Stimulus pushes
//             hand-computed expected results; a monitor pops and compares on
//             every done/err pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_acc_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             nReset;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_hi;
  logic             cy;
  logic             zf;
  logic             busy;
  logic             done;
  logic             err;

  typedef struct {
    logic             is_err;
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic             zf;
    logic [WIDTH-1:0] hi;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_fail;

  alu_acc_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .nReset (nReset),
    .start  (start),
    .op     (op),
    .r      (r),
    .acc    (acc),
    .acc_hi (acc_hi),
    .cy     (cy),
    .zf     (zf),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one single-cycle request and queue its expected result.
  task automatic issue(input logic [3:0] o, input logic [7:0] rv,
                       input logic [7:0] e_acc, input logic e_cy, input logic e_zf,
                       input logic [7:0] e_hi, input logic e_err);
    exp_t e;
    e.is_err = e_err; e.acc = e_acc; e.cy = e_cy; e.zf = e_zf; e.hi = e_hi;
    sb.push_back(e);
    start = 1'b1; op = o; r = rv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: compares every completion against the scoreboard.
  always @(negedge clk) begin
    if (nReset && (done || err)) begin
      chk("done_err_excl", {31'b0, done & err}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: got done=%0b err=%0b expected none", done, err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind_err",  {31'b0, err},  {31'b0, e.is_err});
        chk("kind_done", {31'b0, done}, {31'b0, ~e.is_err});
        chk("acc",       {24'b0, acc},  {24'b0, e.acc});
        chk("cy",        {31'b0, cy},   {31'b0, e.cy});
        chk("zf",        {31'b0, zf},   {31'b0, e.zf});
        chk("acc_hi",    {24'b0, acc_hi}, {24'b0, e.hi});
        chk("busy_at_out", {31'b0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; start = 1'b0; op = 4'd0; r = '0;
    n_vec = 0; n_fail = 0;
    #6 nReset = 1'b1;
    chk("rst_acc",  {24'b0, acc},    32'd0);
    chk("rst_hi",   {24'b0, acc_hi}, 32'd0);
    chk("rst_cy",   {31'b0, cy},     32'd0);
    chk("rst_zf",   {31'b0, zf},     32'd1);
    chk("rst_busy", {31'b0, busy},   32'd0);
    chk("rst_done", {31'b0, done},   32'd0);
    chk("rst_err",  {31'b0, err},    32'd0);
    @(posedge clk); #1;

    // Basic ops, back-to-back
    issue(4'd0, 8'd4, 8'd4,  1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd1, 8'd4, 8'd8,  1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd1, 8'd4, 8'd12, 1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd3, 8'd0, 8'd0,  1'b0, 1'b1, 8'd0, 1'b0);

    // Asynchronous reset pulse mid-cycle while idle
    issue(4'd0, 8'h33, 8'h33, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk); #2;
    nReset = 1'b0; #1;
    chk("async_rst_acc", {24'b0, acc}, 32'd0);
    chk("async_rst_zf",  {31'b0, zf},  32'd1);
    #1 nReset = 1'b1;
    @(posedge clk); #1;

    // Carry chain
    issue(4'd0, 8'd4,   8'd4,   1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd6, 8'd0,   8'd251, 1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd1, 8'd10,  8'd5,   1'b1, 1'b0, 8'd0, 1'b0);
    issue(4'd1, 8'd10,  8'd16,  1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd2, 8'd10,  8'd6,   1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd2, 8'd10,  8'd252, 1'b1, 1'b0, 8'd0, 1'b0);
    issue(4'd2, 8'd10,  8'd241, 1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd0, 8'h80,  8'h80,  1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd8, 8'd0,   8'h00,  1'b1, 1'b1, 8'd0, 1'b0);
    issue(4'd9, 8'd0,   8'h80,  1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd4, 8'h0F,  8'h8F,  1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd5, 8'hFF,  8'h70,  1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd0, 8'hFF,  8'hFF,  1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd1, 8'd1,   8'h00,  1'b1, 1'b1, 8'd0, 1'b0);
    issue(4'd0, 8'd5,   8'd5,   1'b1, 1'b0, 8'd0, 1'b0);
    issue(4'd7, 8'd0,   8'd5,   1'b0, 1'b0, 8'd0, 1'b0);
    issue(4'd2, 8'd5,   8'd0,   1'b0, 1'b1, 8'd0, 1'b0);

    // Illegal ops leave state untouched
    issue(4'd15, 8'd7,  8'd0,   1'b0, 1'b1, 8'd0, 1'b1);
    issue(4'd11, 8'd7,  8'd0,   1'b0, 1'b1, 8'd0, 1'b1);

`ifdef ALU_MUL_EN
    // MUL 200*3 = 0x258
    issue(4'd0, 8'd200, 8'd200, 1'b0, 1'b0, 8'd0, 1'b0);
    begin
      exp_t e;
      e.is_err = 1'b0; e.acc = 8'h58; e.cy = 1'b1; e.zf = 1'b0; e.hi = 8'h02;
      sb.push_back(e);
    end
    start = 1'b1; op = 4'd10; r = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mul_busy", {31'b0, busy}, 32'd1);
      chk("mul_no_done", {31'b0, done}, 32'd0);
      chk("mul_acc_hold", {24'b0, acc}, 32'd200);
      if (i == 2) begin
        start = 1'b1; op = 4'd0; r = 8'd7;
      end
      if (i == 3) start = 1'b0;
    end
    @(negedge clk);
    chk("mul_done_lat", {31'b0, done}, 32'd1);
    chk("mul_busy_end", {31'b0, busy}, 32'd0);
    // Start during the done cycle is accepted
    issue(4'd0, 8'd3, 8'd3, 1'b1, 1'b0, 8'h02, 1'b0);
    issue(4'd0, 8'd9, 8'd9, 1'b1, 1'b0, 8'h02, 1'b0);

    // Reset in the middle of a MUL
    start = 1'b1; op = 4'd10; r = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mulrst_busy_pre", {31'b0, busy}, 32'd1);
    nReset = 1'b0; #1;
    chk("mulrst_acc",  {24'b0, acc},    32'd0);
    chk("mulrst_hi",   {24'b0, acc_hi}, 32'd0);
    chk("mulrst_busy", {31'b0, busy},   32'd0);
    chk("mulrst_cy",   {31'b0, cy},     32'd0);
    chk("mulrst_zf",   {31'b0, zf},     32'd1);
    #2 nReset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mulrst_no_done", {31'b0, done}, 32'd0);
    end
`else
    // MUL not built: op 10 is rejected
    issue(4'd10, 8'd3, 8'd0, 1'b0, 1'b1, 8'd0, 1'b1);
    chk("nomul_busy", {31'b0, busy},   32'd0);
    chk("nomul_hi",   {24'b0, acc_hi}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
